// File: rtl/seg_mux_decoder.sv
// seg_mux_decoder: snoops a two-digit multiplexed 7-segment bus and recovers
// the displayed tens/ones BCD pair. A slot is accepted only after its
// {com,seg} pattern has been stable for STABLE_CYCLES synchronized samples;
// a tens/ones pair is committed only when a full frame decodes cleanly.
// Optional feature macro: SEGDEC_ALARM_EN (compiles in the 99-alarm flop;
// without it alarm is tied to 0).
module seg_mux_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [1:0] com_in,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       value_valid,
  output logic       bcd_err,
  output logic       stale,
  output logic       alarm
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] ACC_AT   = SW'(STABLE_CYCLES - 2);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_PRE = IW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {WAIT_TEN, WAIT_ONE} state_t;

  logic [8:0]    sync1, sync2, hist;
  logic [SW-1:0] stab_cnt;
  logic          accept;
  logic [8:0]    acc_slot;
  logic [IW-1:0] idle_cnt;
  logic          stale_rise;
  state_t        state;
  logic [3:0]    tens_tmp;

  logic [1:0]    acc_com;
  logic          dec_valid;
  logic [3:0]    dec_digit;
  logic          slot_known;
  logic          commit;

  // Two-flop synchronizer for the whole bus, followed by a 1-deep history.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= {com_in, seg_in};
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Stability counter; accept fires once, as the count reaches STABLE_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
      accept   <= 1'b0;
      acc_slot <= '0;
    end else begin
      if (sync2 != hist)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 1'b1;
      accept   <= (sync2 == hist) && (stab_cnt == ACC_AT);
      acc_slot <= hist;
    end
  end

  // Segment decode and frame-commit qualification of the accepted slot.
  // NOTE: every output of an always_comb gets a default first, otherwise
  // unassigned paths infer latches.
  always_comb begin
    acc_com   = acc_slot[8:7];
    dec_valid = 1'b1;
    dec_digit = 4'd0;
    unique case (acc_slot[6:0])
      7'b0111111: dec_digit = 4'd0;
      7'b0000110: dec_digit = 4'd1;
      7'b1011011: dec_digit = 4'd2;
      7'b1001111: dec_digit = 4'd3;
      7'b1100110: dec_digit = 4'd4;
      7'b1101101: dec_digit = 4'd5;
      7'b1111101: dec_digit = 4'd6;
      7'b0000111: dec_digit = 4'd7;
      7'b1111111: dec_digit = 4'd8;
      7'b1100111: dec_digit = 4'd9;
      default:    dec_valid = 1'b0;
    endcase
    slot_known = (acc_com == 2'b01) || (acc_com == 2'b10);
    commit     = accept && slot_known && dec_valid &&
                 (state == WAIT_ONE) && (acc_com == 2'b10);
    stale_rise = !accept && (idle_cnt == IDLE_PRE);
  end

  // Idle counter: restarted by every accept, raises stale at the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      stale    <= 1'b0;
    end else if (accept) begin
      idle_cnt <= '0;
      stale    <= 1'b0;
    end else begin
      if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + 1'b1;
      if (stale_rise)
        stale <= 1'b1;
    end
  end

  // Frame FSM with registered digit outputs and single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_TEN;
      tens_tmp    <= '0;
      tens        <= '0;
      ones        <= '0;
      value_valid <= 1'b0;
      bcd_err     <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      bcd_err     <= 1'b0;
      if (stale_rise) begin
        state <= WAIT_TEN;
      end else if (accept && slot_known) begin
        if (!dec_valid) begin
          bcd_err <= 1'b1;
          state   <= WAIT_TEN;
        end else if (acc_com == 2'b01) begin
          tens_tmp <= dec_digit;
          state    <= WAIT_ONE;
        end else if (state == WAIT_ONE) begin
          tens        <= tens_tmp;
          ones        <= dec_digit;
          value_valid <= 1'b1;
          state       <= WAIT_TEN;
        end
      end
    end
  end

`ifdef SEGDEC_ALARM_EN
  // Alarm tracks whether the committed value is 99 while the bus is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      alarm <= 1'b0;
    else if (stale_rise)
      alarm <= 1'b0;
    else if (commit)
      alarm <= (tens_tmp == 4'd9) && (dec_digit == 4'd9);
  end
`else
  // Alarm feature not built: output held low.
  assign alarm = 1'b0;
`endif

endmodule
